// File: rtl/piece_dispenser.sv
// ============================================================================
// piece_dispenser : double-buffered consumer of randombag bags with a
//                   valid/take piece interface and a one-ahead preview.
// Revision        : 1.0
// ============================================================================
`default_nettype none

module piece_dispenser #(
  parameter int PIECE_W = 3,
  parameter int BAG_N   = 7,
  parameter int TIMEOUT = 64
) (
  input  logic                       clk,
  input  logic                       nreset,
  output logic                       newbag,
  input  logic                       ready,
  input  logic [PIECE_W*BAG_N-1:0]   pieces,
  input  logic                       take,
  output logic [PIECE_W-1:0]         piece,
  output logic                       piece_valid,
  output logic [PIECE_W-1:0]         preview,
  output logic                       preview_valid,
  output logic [7:0]                 retries
);

  localparam int BAG_W = PIECE_W * BAG_N;
  localparam int IDX_W = $clog2(BAG_N);
  localparam int TMR_W = $clog2(TIMEOUT + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BAG_N - 1);
  localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(TIMEOUT);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic [7:0]       retries_q, retries_d;
  logic             ready_q;
  logic [BAG_W-1:0] active_q, active_d, pending_q, pending_d;
  logic             active_v_q, active_v_d, pending_v_q, pending_v_d;
  logic [IDX_W-1:0] idx_q, idx_d, next_idx;

  logic cap, last, exhaust, cap_to_active;

  assign cap           = ready & ~ready_q & (state_q == S_WAIT);
  assign last          = (idx_q == LAST_IDX);
  assign exhaust       = take & active_v_q & last;
  assign cap_to_active = ~active_v_q | (exhaust & ~pending_v_q);
  assign next_idx      = last ? idx_q : idx_q + IDX_W'(1);

  // Fetch FSM: state register
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q   <= S_IDLE;
      timer_q   <= '0;
      retries_q <= '0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      retries_q <= retries_d;
    end
  end

  // Fetch FSM: next state; a capture wins over a simultaneous timeout
  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    retries_d = retries_q;
    case (state_q)
      S_IDLE: if (!pending_v_q) state_d = S_REQ;
      S_REQ: begin
        state_d = S_WAIT;
        timer_d = TMR_LOAD;
      end
      S_WAIT: begin
        if (cap) begin
          state_d = S_IDLE;
        end else if (timer_q == '0) begin
          state_d = S_REQ;
          if (retries_q != 8'hFF) retries_d = retries_q + 8'd1;
        end else begin
          timer_d = timer_q - TMR_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Fetch FSM: outputs
  always_comb begin
    newbag  = (state_q == S_REQ);
    retries = retries_q;
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      ready_q     <= 1'b0;
      active_q    <= '0;
      active_v_q  <= 1'b0;
      pending_q   <= '0;
      pending_v_q <= 1'b0;
      idx_q       <= '0;
    end else begin
      ready_q     <= ready;
      active_q    <= active_d;
      active_v_q  <= active_v_d;
      pending_q   <= pending_d;
      pending_v_q <= pending_v_d;
      idx_q       <= idx_d;
    end
  end

  always_comb begin
    active_d    = active_q;
    active_v_d  = active_v_q;
    pending_d   = pending_q;
    pending_v_d = pending_v_q;
    idx_d       = idx_q;
    if (exhaust) begin
      idx_d = '0;
      if (pending_v_q) begin
        active_d    = pending_q;
        pending_v_d = 1'b0;
      end else begin
        active_v_d  = 1'b0;
      end
    end else if (take && active_v_q) begin
      idx_d = idx_q + IDX_W'(1);
    end
    // A capture landing on an exhausting take refills active with no gap
    if (cap) begin
      if (cap_to_active) begin
        active_d   = pieces;
        active_v_d = 1'b1;
        idx_d      = '0;
      end else begin
        pending_d   = pieces;
        pending_v_d = 1'b1;
      end
    end
  end

  always_comb begin
    piece_valid   = active_v_q;
    piece         = active_v_q ? active_q[PIECE_W*int'(idx_q) +: PIECE_W] : '0;
    preview_valid = last ? pending_v_q : active_v_q;
    if (last)
      preview = pending_v_q ? pending_q[PIECE_W-1:0] : '0;
    else
      preview = active_v_q ? active_q[PIECE_W*int'(next_idx) +: PIECE_W] : '0;
  end

endmodule

`default_nettype wire

// File: tb/tb_piece_dispenser.sv
// ============================================================================
// tb_piece_dispenser : scoreboard bench for piece_dispenser with a randombag
//                      responder model.
// Revision           : 1.0
// ============================================================================
`default_nettype none

module tb_piece_dispenser;

  localparam logic [20:0] BAG_A = 21'o6543210;
  localparam logic [20:0] BAG_B = 21'o0123456;
  localparam logic [20:0] BAG_C = 21'o5555553;
  localparam logic [20:0] BAG_D = 21'o2107654;

  logic        clk = 1'b0;
  logic        nreset = 1'b0;
  logic        take = 1'b0;
  logic        newbag, piece_valid, preview_valid;
  logic [2:0]  piece, preview;
  logic [7:0]  retries;
  logic        ready_w;
  logic [20:0] pieces_w;

  logic        m_ready, man_ready = 1'b0;
  logic [20:0] m_pieces, man_pieces = '0;
  bit          man_mode = 1'b0;
  bit          model_en = 1'b0;
  bit          model_hold = 1'b0;
  int          model_delay = 1;
  logic [20:0] bag_q[$];

  typedef struct {
    logic [2:0] pc;
    logic [2:0] pv;
    logic       pvv;
  } exp_t;
  exp_t exp_q[$];

  int  checks = 0;
  int  errors = 0;
  bit  gap_chk = 1'b0;
  int  nb_count = 0;
  bit  nb_prev = 1'b0;

  assign ready_w  = man_mode ? man_ready  : m_ready;
  assign pieces_w = man_mode ? man_pieces : m_pieces;

  piece_dispenser dut (
    .clk           (clk),
    .nreset        (nreset),
    .newbag        (newbag),
    .ready         (ready_w),
    .pieces        (pieces_w),
    .take          (take),
    .piece         (piece),
    .piece_valid   (piece_valid),
    .preview       (preview),
    .preview_valid (preview_valid),
    .retries       (retries)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic push(input int pc, input int pv, input bit pvv);
    exp_t e;
    e.pc  = 3'(pc);
    e.pv  = 3'(pv);
    e.pvv = pvv;
    exp_q.push_back(e);
  endtask

  // randombag responder
  initial begin
    m_ready  = 1'b0;
    m_pieces = '0;
    forever begin
      @(negedge clk);
      if (!model_en) begin
        m_ready = 1'b0;
      end else if (newbag && bag_q.size() > 0) begin
        repeat (model_delay) @(posedge clk);
        #1;
        m_pieces = bag_q.pop_front();
        m_ready  = 1'b1;
        if (!model_hold) begin
          @(posedge clk);
          #1;
          m_ready = 1'b0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (newbag && !nb_prev) nb_count++;
    nb_prev = newbag;
  end

  // scoreboard monitor
  always @(negedge clk) begin
    exp_t e;
    if (nreset && take && piece_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected piece actual=%0d required=none", piece);
      end else begin
        e = exp_q.pop_front();
        chk("sb_piece", 32'(piece), 32'(e.pc));
        chk("sb_preview_valid", 32'(preview_valid), 32'(e.pvv));
        if (e.pvv) chk("sb_preview", 32'(preview), 32'(e.pv));
      end
    end
    if (gap_chk) chk("no_valid_gap", 32'(piece_valid), 1);
  end

  task automatic start_reset();
    @(posedge clk);
    #1;
    nreset   = 1'b0;
    take     = 1'b0;
    model_en = 1'b0;
    man_mode = 1'b0;
    exp_q.delete();
    bag_q.delete();
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic release_reset();
    nreset = 1'b1;
  endtask

  task automatic take_n(input int n, input bit gaps);
    @(posedge clk);
    #1;
    take    = 1'b1;
    gap_chk = gaps;
    repeat (n) @(posedge clk);
    #1;
    gap_chk = 1'b0;
  endtask

  int p1_pc[14] = '{0, 1, 2, 3, 4, 5, 6, 6, 5, 4, 3, 2, 1, 0};
  int p1_pv[14] = '{1, 2, 3, 4, 5, 6, 6, 5, 4, 3, 2, 1, 0, 3};

  initial begin
    int nb0;
    int k, last_c, cyc;
    bit prev, done, seen;

    // reset values
    repeat (2) @(negedge clk);
    chk("rst_newbag", 32'(newbag), 0);
    chk("rst_piece_valid", 32'(piece_valid), 0);
    chk("rst_preview_valid", 32'(preview_valid), 0);
    chk("rst_piece", 32'(piece), 0);
    chk("rst_preview", 32'(preview), 0);
    chk("rst_retries", 32'(retries), 0);

    // startup prefetch and continuous take across a bag boundary
    start_reset();
    model_en = 1'b1; model_hold = 1'b0; model_delay = 1;
    bag_q.push_back(BAG_A); bag_q.push_back(BAG_B); bag_q.push_back(BAG_C);
    nb0 = nb_count;
    release_reset();
    repeat (20) @(negedge clk);
    chk("startup_newbag_pulses", 32'(nb_count - nb0), 2);
    chk("startup_piece", 32'(piece), 0);
    chk("startup_preview", 32'(preview), 1);
    chk("startup_valid", 32'(piece_valid), 1);
    for (int i = 0; i < 14; i++) push(p1_pc[i], p1_pv[i], 1'b1);
    take_n(14, 1'b1);
    take = 1'b0;
    @(negedge clk);
    chk("seq_drained", 32'(exp_q.size()), 0);
    chk("bag3_piece", 32'(piece), 3);
    chk("bag3_preview", 32'(preview), 5);
    repeat (10) @(negedge clk);
    chk("seq_newbag_pulses", 32'(nb_count - nb0), 4);

    // ready held high: no recapture, request times out
    start_reset();
    model_en = 1'b1; model_hold = 1'b1; model_delay = 1;
    bag_q.push_back(BAG_A);
    release_reset();
    repeat (100) @(negedge clk);
    chk("hold_retries", 32'(retries), 1);
    chk("hold_valid", 32'(piece_valid), 1);
    for (int i = 0; i < 7; i++) push(i, i + 1, (i < 6));
    take_n(7, 1'b0);
    take = 1'b0;
    @(negedge clk);
    chk("hold_no_second_bag", 32'(piece_valid), 0);
    chk("hold_drained", 32'(exp_q.size()), 0);

    // slow responder: drain, ignored takes, refill
    start_reset();
    model_en = 1'b1; model_hold = 1'b0; model_delay = 200;
    bag_q.push_back(BAG_A); bag_q.push_back(BAG_B); bag_q.push_back(BAG_D);
    release_reset();
    repeat (450) @(negedge clk);
    chk("slow_loaded", 32'(piece_valid), 1);
    for (int i = 0; i < 14; i++) push(p1_pc[i], p1_pv[i], (i < 13));
    take_n(14, 1'b1);
    @(negedge clk);
    chk("drain_valid_low", 32'(piece_valid), 0);
    chk("drain_sb_empty", 32'(exp_q.size()), 0);
    repeat (5) @(posedge clk);
    #1;
    take = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 400 && !seen; c++) begin
      @(negedge clk);
      if (ready_w) seen = 1'b1;
    end
    if (!seen) begin
      checks++; errors++;
      $display("FAIL refill_ready_timeout actual=no_ready required=ready");
    end
    chk("refill_not_yet", 32'(piece_valid), 0);
    @(negedge clk);
    chk("refill_valid", 32'(piece_valid), 1);
    chk("refill_piece", 32'(piece), 4);
    chk("refill_preview", 32'(preview), 5);

    // responder silent: periodic retries and saturation
    start_reset();
    release_reset();
    k = 0; last_c = 0; cyc = 0; prev = 1'b0; done = 1'b0;
    for (int c = 0; c < 300 * 66 && !done; c++) begin
      @(negedge clk);
      cyc++;
      if (newbag && !prev) begin
        k++;
        if (k <= 4) chk("retry_count", 32'(retries), 32'(k - 1));
        if (k >= 2 && k <= 4) chk("retry_period", 32'(cyc - last_c), 66);
        last_c = cyc;
      end
      prev = newbag;
      if (retries == 8'd255) done = 1'b1;
    end
    chk("retries_reach_255", 32'(retries), 255);
    repeat (140) @(negedge clk);
    chk("retries_saturated", 32'(retries), 255);

    // reset during WAIT with a ready edge inside the reset window
    seen = 1'b0;
    for (int c = 0; c < 100 && !seen; c++) begin
      @(negedge clk);
      if (newbag) seen = 1'b1;
    end
    if (!seen) begin
      checks++; errors++;
      $display("FAIL wait_newbag_timeout actual=no_pulse required=pulse");
    end
    repeat (3) @(negedge clk);
    @(posedge clk);
    #1;
    nreset     = 1'b0;
    man_mode   = 1'b1;
    man_pieces = BAG_A;
    man_ready  = 1'b0;
    #2 man_ready = 1'b1;
    @(negedge clk);
    chk("mid_rst_newbag", 32'(newbag), 0);
    chk("mid_rst_retries", 32'(retries), 0);
    chk("mid_rst_piece_valid", 32'(piece_valid), 0);
    chk("mid_rst_preview_valid", 32'(preview_valid), 0);
    repeat (2) @(posedge clk);
    #1;
    nreset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("post_rst_newbag", 32'(newbag), 1);
    chk("post_rst_no_capture", 32'(piece_valid), 0);
    man_ready = 1'b0;
    repeat (5) @(negedge clk);
    chk("post_rst_still_empty", 32'(piece_valid), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
